// File: rtl/ptp_rtc_pkg.sv
// Shared constants and helpers for the PTPv2 real-time clock.
package ptp_rtc_pkg;

  // Nanosecond-field modulus (one second).
  localparam logic [31:0] RTC_NS_PER_SEC = 32'd1_000_000_000;

  // Reset increment: 6.4 ns per cycle, i.e. a 156.25 MHz clock.
  localparam logic [31:0] RTC_INC_RST = 32'h0006_6666;

  // Block address reserved for the future bus wrapper.
  localparam logic [7:0] RTC_BLK_ADDR = 8'h40;

  // Turn a sign flag and an unsigned magnitude into a 34-bit signed offset.
  function automatic logic signed [33:0] signed_adj(input logic neg,
                                                    input logic [31:0] mag);
    logic signed [33:0] m;
    m = $signed({2'b00, mag});
    return neg ? -m : m;
  endfunction

endpackage

// File: rtl/rtc_ns_norm.sv
// Combinational nanosecond normaliser: adds the integer increment, the
// fraction carry and a signed offset to ns, then folds the result back
// into [0, NS_PER_SEC) with at most one correction in either direction.
module rtc_ns_norm
  import ptp_rtc_pkg::*;
#(
  parameter logic [31:0] NS_PER_SEC = RTC_NS_PER_SEC
) (
  input  logic [31:0]        ns_i,
  input  logic [15:0]        inc_ns_i,
  input  logic               frac_c_i,
  input  logic signed [33:0] adj_i,
  output logic [31:0]        ns_o,
  output logic               sec_inc_o,
  output logic               sec_dec_o
);

  logic signed [33:0] t;

  // Sum everything in 34-bit signed, then correct by one second if needed.
  // The 32-bit corrections wrap modulo 2^32, which is exact because the
  // corrected value is always inside [0, NS_PER_SEC).
  always_comb begin
    t         = $signed({2'b00, ns_i}) + $signed({18'b0, inc_ns_i})
              + $signed({33'b0, frac_c_i}) + adj_i;
    ns_o      = t[31:0];
    sec_inc_o = 1'b0;
    sec_dec_o = 1'b0;
    if (t[33]) begin
      ns_o      = t[31:0] + NS_PER_SEC;
      sec_dec_o = 1'b1;
    end else if (t >= $signed({2'b00, NS_PER_SEC})) begin
      ns_o      = t[31:0] - NS_PER_SEC;
      sec_inc_o = 1'b1;
    end
  end

endmodule

// File: rtl/ptp_rtc.sv
// Free-running PTPv2 real-time clock with load, signed adjust, programmable
// increment (frequency trim), second-boundary pulse and reject pulse.
// Per-cycle priority: load, then adjust, then the plain increment.
module ptp_rtc
  import ptp_rtc_pkg::*;
#(
  parameter logic [31:0] NS_PER_SEC = RTC_NS_PER_SEC,
  parameter logic [31:0] INC_RST    = RTC_INC_RST
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst_n,
  input  logic        rtc_en_i,
  input  logic        inc_wr_i,
  input  logic [31:0] inc_i,
  input  logic        load_i,
  input  logic [47:0] load_sec_i,
  input  logic [31:0] load_ns_i,
  input  logic        adj_i,
  input  logic        adj_neg_i,
  input  logic [31:0] adj_ns_i,
  output logic [79:0] rtc_std_o,
  output logic [15:0] rtc_fns_o,
  output logic        pps_o,
  output logic        err_o
);

  logic [47:0] sec_q;
  logic [31:0] ns_q;
  logic [15:0] fns_q;
  logic [31:0] inc_q;
  logic        pps_q;
  logic        err_q;

  logic [31:0]        inc_eff;
  logic               frac_c;
  logic [15:0]        fns_sum;
  logic               load_ok;
  logic               load_bad;
  logic               adj_bad;
  logic               adj_ok;
  logic signed [33:0] adj_val;
  logic [31:0]        ns_norm;
  logic               sec_inc;
  logic               sec_dec;

  // Decode the per-cycle operation: effective increment, fraction sum,
  // which of load/adjust is accepted, and the signed offset to apply.
  always_comb begin
    inc_eff           = rtc_en_i ? inc_q : 32'd0;
    {frac_c, fns_sum} = {1'b0, fns_q} + {1'b0, inc_eff[15:0]};
    load_bad          = load_i && (load_ns_i >= NS_PER_SEC);
    load_ok           = load_i && !load_bad;
    adj_bad           = adj_i && (adj_ns_i >= NS_PER_SEC);
    // A valid load overrides any adjust in the same cycle.
    adj_ok            = adj_i && !adj_bad && !load_ok;
    adj_val           = adj_ok ? signed_adj(adj_neg_i, adj_ns_i) : 34'sd0;
  end

  rtc_ns_norm #(
    .NS_PER_SEC (NS_PER_SEC)
  ) u_ns_norm (
    .ns_i      (ns_q),
    .inc_ns_i  (inc_eff[31:16]),
    .frac_c_i  (frac_c),
    .adj_i     (adj_val),
    .ns_o      (ns_norm),
    .sec_inc_o (sec_inc),
    .sec_dec_o (sec_dec)
  );

  // Time registers: absolute load wins, otherwise take the normalised sum.
  // Seconds wrap modulo 2^48 in both directions.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      sec_q <= '0;
      ns_q  <= '0;
      fns_q <= '0;
      pps_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (load_ok) begin
        sec_q <= load_sec_i;
        ns_q  <= load_ns_i;
        fns_q <= '0;
      end else begin
        ns_q  <= ns_norm;
        fns_q <= fns_sum;
        if (sec_inc)      sec_q <= sec_q + 48'd1;
        else if (sec_dec) sec_q <= sec_q - 48'd1;
      end
      pps_q <= !load_ok && sec_inc;
      // An adjust masked by a valid load is not a rejection.
      err_q <= load_bad || (adj_bad && !load_ok);
    end
  end

  // Increment register; a write is used from the following cycle onward.
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) inc_q <= INC_RST;
    else if (inc_wr_i) inc_q <= inc_i;
  end

  assign rtc_std_o = {sec_q, ns_q};
  assign rtc_fns_o = fns_q;
  assign pps_o     = pps_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ptp_rtc.sv
// Directed bench for ptp_rtc: inputs change on the falling edge, outputs are
// sampled on the falling edge, so each tick spans exactly one rising edge.
module tb_ptp_rtc;

  logic        rtc_clk;
  logic        rtc_rst_n;
  logic        rtc_en_i;
  logic        inc_wr_i;
  logic [31:0] inc_i;
  logic        load_i;
  logic [47:0] load_sec_i;
  logic [31:0] load_ns_i;
  logic        adj_i;
  logic        adj_neg_i;
  logic [31:0] adj_ns_i;
  logic [79:0] rtc_std_o;
  logic [15:0] rtc_fns_o;
  logic        pps_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  ptp_rtc dut (
    .rtc_clk    (rtc_clk),
    .rtc_rst_n  (rtc_rst_n),
    .rtc_en_i   (rtc_en_i),
    .inc_wr_i   (inc_wr_i),
    .inc_i      (inc_i),
    .load_i     (load_i),
    .load_sec_i (load_sec_i),
    .load_ns_i  (load_ns_i),
    .adj_i      (adj_i),
    .adj_neg_i  (adj_neg_i),
    .adj_ns_i   (adj_ns_i),
    .rtc_std_o  (rtc_std_o),
    .rtc_fns_o  (rtc_fns_o),
    .pps_o      (pps_o),
    .err_o      (err_o)
  );

  // Clock: 10 ns period.
  initial rtc_clk = 1'b0;
  always #5 rtc_clk = ~rtc_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge rtc_clk);
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the whole visible time state in one go.
  task automatic chk_time(input string tag, input logic [47:0] sec, input logic [31:0] ns,
                          input logic [15:0] fns);
    chk({tag, "_sec"}, 80'(rtc_std_o[79:32]), 80'(sec));
    chk({tag, "_ns"},  80'(rtc_std_o[31:0]),  80'(ns));
    chk({tag, "_fns"}, 80'(rtc_fns_o),        80'(fns));
  endtask

  task automatic do_load(input logic [47:0] sec, input logic [31:0] ns);
    load_i = 1'b1; load_sec_i = sec; load_ns_i = ns;
    tick(1);
    load_i = 1'b0;
  endtask

  task automatic do_adj(input logic neg, input logic [31:0] ns);
    adj_i = 1'b1; adj_neg_i = neg; adj_ns_i = ns;
    tick(1);
    adj_i = 1'b0;
  endtask

  initial begin
    rtc_rst_n = 1'b0; rtc_en_i = 1'b0; inc_wr_i = 1'b0; inc_i = '0;
    load_i = 1'b0; load_sec_i = '0; load_ns_i = '0;
    adj_i = 1'b0; adj_neg_i = 1'b0; adj_ns_i = '0;
    tick(3);

    // Reset state.
    chk("rst_std", 80'(rtc_std_o), 80'd0);
    chk("rst_fns", 80'(rtc_fns_o), 80'd0);
    chk("rst_pps", 80'(pps_o), 80'd0);
    chk("rst_err", 80'(err_o), 80'd0);

    // Ten increments of 0x6_6666: 10 * 0x6666 = 0x3FFFC gives 3 ns of
    // carry and 0xFFFC fraction, so 60 + 3 = 63 ns (6.4 is not exact in
    // 16 fractional bits).
    rtc_en_i = 1'b1;
    rtc_rst_n = 1'b1;
    tick(10);
    chk_time("inc10", 48'd0, 32'd63, 16'hFFFC);

    // Rollover: load lands with zero fraction, next step crosses 1 s.
    do_load(48'd5, 32'd999_999_995);
    chk_time("roll_ld", 48'd5, 32'd999_999_995, 16'h0000);
    chk("roll_ld_pps", 80'(pps_o), 80'd0);
    tick(1);
    chk_time("roll", 48'd6, 32'd1, 16'h6666);
    chk("roll_pps", 80'(pps_o), 80'd1);
    tick(1);
    chk("roll_pps_end", 80'(pps_o), 80'd0);
    chk("roll_ns2", 80'(rtc_std_o[31:0]), 80'd7);

    // Negative adjust with borrow while the clock is held.
    rtc_en_i = 1'b0;
    do_load(48'd10, 32'd100);
    do_adj(1'b1, 32'd200);
    chk_time("nadj", 48'd9, 32'd999_999_900, 16'h0000);
    chk("nadj_pps", 80'(pps_o), 80'd0);
    chk("nadj_err", 80'(err_o), 80'd0);

    // Seconds underflow wraps to all ones.
    do_load(48'd0, 32'd0);
    do_adj(1'b1, 32'd1);
    chk_time("uflow", 48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0000);
    // And a +1 adjust carries straight back over the wrap with a pulse.
    do_adj(1'b0, 32'd1);
    chk_time("oflow", 48'd0, 32'd0, 16'h0000);
    chk("oflow_pps", 80'(pps_o), 80'd1);

    // Load and adjust together: load wins, adjust silently dropped.
    load_i = 1'b1; load_sec_i = 48'd1; load_ns_i = 32'd0;
    adj_i = 1'b1; adj_neg_i = 1'b0; adj_ns_i = 32'd500;
    tick(1);
    load_i = 1'b0; adj_i = 1'b0;
    chk_time("ld_adj", 48'd1, 32'd0, 16'h0000);
    chk("ld_adj_err", 80'(err_o), 80'd0);

    // Out-of-range adjust: rejected, plain 6.4 ns increment still applies.
    rtc_en_i = 1'b1;
    do_adj(1'b0, 32'd1_000_000_000);
    chk("badadj_err", 80'(err_o), 80'd1);
    chk_time("badadj", 48'd1, 32'd6, 16'h6666);
    tick(1);
    chk("badadj_err_end", 80'(err_o), 80'd0);
    chk_time("badadj2", 48'd1, 32'd12, 16'hCCCC);

    // Out-of-range load: ignored, time proceeds (0xCCCC+0x6666 carries).
    do_load(48'd77, 32'd1_000_000_000);
    chk("badld_err", 80'(err_o), 80'd1);
    chk_time("badld", 48'd1, 32'd19, 16'h3332);

    // Increment change coinciding with a load; 8 ns steps from next cycle.
    inc_wr_i = 1'b1; inc_i = 32'h0008_0000;
    do_load(48'd2, 32'd0);
    inc_wr_i = 1'b0;
    chk_time("inc8_ld", 48'd2, 32'd0, 16'h0000);
    tick(1);
    chk_time("inc8_1", 48'd2, 32'd8, 16'h0000);
    tick(4);
    chk_time("inc8_5", 48'd2, 32'd40, 16'h0000);

    // Asynchronous reset mid-count clears outputs without a clock edge.
    #2;
    rtc_rst_n = 1'b0;
    #1;
    chk("arst_std", 80'(rtc_std_o), 80'd0);
    chk("arst_fns", 80'(rtc_fns_o), 80'd0);
    tick(1);
    rtc_rst_n = 1'b1;
    tick(1);
    // Increment is back at its reset value of 0x6_6666.
    chk_time("arst_inc", 48'd0, 32'd6, 16'h6666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
